// File: rtl/subbytes_scheduler_if.sv
// Request/response bundle between the round controller / key expansion and the
// shared SubBytes engine. The engine uses the slave modport.
interface subbytes_scheduler_if;
    logic         st_valid;
    logic         st_ready;
    logic [0:127] st_in;
    logic [0:127] st_out;
    logic         st_done;
    logic         key_valid;
    logic         key_ready;
    logic [0:31]  key_in;
    logic [0:31]  key_out;
    logic         key_done;

    modport slave (
        input  st_valid, st_in, key_valid, key_in,
        output st_ready, st_out, st_done, key_ready, key_out, key_done
    );

    modport master (
        output st_valid, st_in, key_valid, key_in,
        input  st_ready, st_out, st_done, key_ready, key_out, key_done
    );
endinterface

// File: rtl/subbytes_scheduler.sv
// One 32-bit S-box slice shared between a 4-pass state port and a 1-pass key port.
// Key port logic is present only when SUBBYTES_SCHED_KEY_PORT_EN is defined.
//
// state   | meaning
// IDLE    | arbitrating, readies may be high
// ST_RUN  | substituting state word r_wcnt, done after word 3
// KEY_RUN | substituting the captured key word (single pass)
module subbytes_scheduler (
    input  logic                  i_clk,
    input  logic                  i_rst,
    subbytes_scheduler_if.slave   io_bus,
    output logic                  o_busy
);

`ifdef SUBBYTES_SCHED_KEY_PORT_EN
    typedef enum logic [1:0] {IDLE, ST_RUN, KEY_RUN} state_t;
`else
    typedef enum logic [1:0] {IDLE, ST_RUN} state_t;
`endif

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_wcnt;
    logic [0:127] r_st_cap;
    logic [0:127] r_st_out;
    logic         r_st_done;
    logic         w_st_ready;
    logic         w_st_acc;
    logic [0:31]  w_slice_in;
    logic [0:31]  w_slice_out;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        w_slice_out = '0;
        for (int b = 0; b < 4; b++) begin
            w_slice_out[8*b +: 8] = sbox(w_slice_in[8*b +: 8]);
        end
    end

`ifdef SUBBYTES_SCHED_KEY_PORT_EN
    logic        r_last_grant_key;
    logic [0:31] r_key_cap;
    logic [0:31] r_key_out;
    logic        r_key_done;
    logic        w_key_ready;
    logic        w_key_acc;

    assign w_slice_in = (r_state == KEY_RUN) ? r_key_cap : r_st_cap[{r_wcnt, 5'd0} +: 32];

    always_comb begin
        w_state_nxt = r_state;
        w_st_ready  = 1'b0;
        w_key_ready = 1'b0;
        w_st_acc    = 1'b0;
        w_key_acc   = 1'b0;
        case (r_state)
            IDLE: begin
                w_st_ready  = !i_rst && (!io_bus.key_valid || r_last_grant_key);
                w_key_ready = !i_rst && (!io_bus.st_valid || !r_last_grant_key);
                w_st_acc    = w_st_ready && io_bus.st_valid;
                w_key_acc   = w_key_ready && io_bus.key_valid;
                if (w_st_acc)       w_state_nxt = ST_RUN;
                else if (w_key_acc) w_state_nxt = KEY_RUN;
            end
            ST_RUN:  if (r_wcnt == 2'd3) w_state_nxt = IDLE;
            KEY_RUN: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant_key <= 1'b1;
            r_key_cap        <= '0;
            r_key_out        <= '0;
            r_key_done       <= 1'b0;
        end else begin
            r_key_done <= 1'b0;
            if (w_st_acc)  r_last_grant_key <= 1'b0;
            if (w_key_acc) begin
                r_last_grant_key <= 1'b1;
                r_key_cap        <= io_bus.key_in;
            end
            if (r_state == KEY_RUN) begin
                r_key_out  <= w_slice_out;
                r_key_done <= 1'b1;
            end
        end
    end

    assign io_bus.key_ready = w_key_ready;
    assign io_bus.key_out   = r_key_out;
    assign io_bus.key_done  = r_key_done;
`else
    logic w_key_unused;

    assign w_key_unused = ^{io_bus.key_valid, io_bus.key_in};
    assign w_slice_in   = r_st_cap[{r_wcnt, 5'd0} +: 32];

    always_comb begin
        w_state_nxt = r_state;
        w_st_ready  = 1'b0;
        w_st_acc    = 1'b0;
        case (r_state)
            IDLE: begin
                w_st_ready = !i_rst;
                w_st_acc   = w_st_ready && io_bus.st_valid;
                if (w_st_acc) w_state_nxt = ST_RUN;
            end
            ST_RUN:  if (r_wcnt == 2'd3) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign io_bus.key_ready = 1'b0;
    assign io_bus.key_out   = '0;
    assign io_bus.key_done  = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_wcnt    <= 2'd0;
            r_st_cap  <= '0;
            r_st_out  <= '0;
            r_st_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_st_done <= 1'b0;
            if (w_st_acc) r_st_cap <= io_bus.st_in;
            // Words land in st_out as they finish; only the done cycle shows a full result.
            if (r_state == ST_RUN) begin
                r_st_out[{r_wcnt, 5'd0} +: 32] <= w_slice_out;
                r_wcnt                         <= r_wcnt + 2'd1;
                if (r_wcnt == 2'd3) r_st_done <= 1'b1;
            end
        end
    end

    assign io_bus.st_ready = w_st_ready;
    assign io_bus.st_out   = r_st_out;
    assign io_bus.st_done  = r_st_done;
    assign o_busy          = (r_state != IDLE);

endmodule

// File: doc/subbytes_scheduler.md
# subbytes_scheduler

Time-multiplexed SubBytes engine that shares one 32-bit S-box slice (four byte S-box lookups) between two requesters. The state port substitutes a full 128-bit AES state over four passes. The key port substitutes a single 32-bit word, the SubWord step of key expansion. The block sits between the round controller and the key-expansion unit and replaces two full-width SubBytes instances with one quarter-width shared datapath.

## Interface
- No parameters. Widths are fixed by AES.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  state request pending
- st_ready  out  1  state request accepted this cycle when st_valid is also high
- st_in  in  [0:127]  state to substitute; byte 0 is bits [0:7]
- st_out  out  [0:127]  substituted state; held until the next state acceptance
- st_done  out  1  one-cycle pulse; st_out is valid
- key_valid  in  1  SubWord request pending
- key_ready  out  1  key request accepted this cycle
- key_in  in  [0:31]  word to substitute
- key_out  out  [0:31]  substituted word; held until the next key acceptance
- key_done  out  1  one-cycle pulse; key_out is valid
- busy  out  1  high while the FSM is outside IDLE

## Operation
- FSM states:
  - IDLE
  - ST_RUN, with 2-bit word counter wcnt
  - KEY_RUN
- Acceptance:
  - A request is accepted on the rising edge where its valid and ready are both high.
  - The input is captured into an internal register at acceptance, so the requester may change st_in or key_in afterwards.
- Ready rules (combinational):
  - st_ready = IDLE & !rst & (!key_valid | last_grant==KEY).
  - key_ready = IDLE & !rst & (!st_valid | last_grant==ST).
  - Both readies are low in every other state.
- Arbitration:
  - Round-robin, evaluated only in IDLE.
  - The last_grant register updates on each acceptance and resets to KEY, so the state port wins the first tie.
  - There is no preemption. A granted transaction runs to completion.
- ST_RUN:
  - wcnt counts 0..3.
  - Each cycle, word wcnt of the captured state (bits [32*wcnt : 32*wcnt+31]) passes through the slice and is written into the same word of st_out.
  - After word 3 the FSM returns to IDLE.
- KEY_RUN:
  - Exactly one pass through the slice, written to key_out.
  - Then the FSM returns to IDLE.
- st_out words are overwritten progressively during ST_RUN. Consumers must sample st_out only on st_done.
- The S-box is the FIPS-197 forward table, implemented as combinational logic inside the block.

## Timing
- Reset values:
  - st_out = 0, key_out = 0
  - st_done = 0, key_done = 0
  - busy = 0
  - FSM = IDLE, wcnt = 0, last_grant = KEY
- State request accepted at edge T:
  - Words 0..3 are written at edges T+1..T+4.
  - st_done is high in the cycle after edge T+4.
  - Latency is 4 cycles from acceptance to st_done.
- Key request accepted at edge T:
  - key_out is written at edge T+1.
  - key_done is high in the cycle after edge T+1.
- Back-to-back requests:
  - The FSM is in IDLE during the done cycle, so a new request may be accepted at the edge that ends the done cycle.
  - State throughput is one block per 5 cycles. Key throughput is one word per 2 cycles.
- Both valid in IDLE: exactly one port is accepted. The other port's ready is low that cycle.
- A valid that drops before acceptance is not remembered.
- rst during ST_RUN or KEY_RUN:
  - The transaction is aborted and all outputs return to their reset values at that edge.
  - No done pulse is issued.
  - The aborted request is not replayed.

## Configuration
- SUBBYTES_SCHED_KEY_PORT_EN defined:
  - Key port, KEY_RUN state and round-robin logic are present, as described above.
- SUBBYTES_SCHED_KEY_PORT_EN not defined:
  - The key port is still present but inert: key_ready, key_done and key_out are tied to 0, and key_valid is ignored.
  - The KEY_RUN state and last_grant are removed.
  - st_ready = IDLE & !rst.

## Test plan
- FIPS-197 state: st_in = 193de3be_a0f4e22b_9ac68d2a_e9f84808 -> st_done 4 cycles after acceptance, st_out = d42711ae_e0bf98f1_b8b45de5_1e415230, busy high for 4 cycles.
- Key SubWord: key_in = cf4f3c09 -> key_done 1 cycle after acceptance, key_out = 8a84eb01.
- Simultaneous st_valid and key_valid from reset -> state granted first. Key granted at the edge ending the st_done cycle, with key_out = 8a84eb01. On the next tie the state port wins again.
- Continuous back-to-back state requests -> one acceptance every 5 cycles. st_done pulses are exactly 1 cycle wide.
- Change st_in during ST_RUN -> st_out equals the substitution of the captured value.
- rst asserted at word 2 of ST_RUN -> outputs are zero next cycle, no st_done, and st_ready is high in the first cycle after rst deasserts with st_valid high.
